vga_line_prefetch: RTL and testbench

- Upstream pixel source for vga_ctl: drives its VGA_RGB input from hcount, vcount and VGA_DE.
- Fetches low-resolution frame-buffer lines from a word-addressed read port into a double-buffered (ping-pong) line buffer.
- Upscales by 2^SCALE_SH in both axes by pixel and line replication.
- One bank is displayed while the other is filled during the preceding output lines.

---
 rtl/vga_line_prefetch_if.sv | 32 +++
 rtl/vga_line_prefetch.sv | 176 +++++++++++++++++
 tb/tb_vga_line_prefetch.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_line_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_line_prefetch_if
// Purpose  : Word-addressed frame-buffer read port (request/grant, in-order returns).
// Revision : 1.0 - initial release
// ============================================================================
interface vga_line_prefetch_if #(
    parameter int ADDR_W = 20
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [23:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/vga_line_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : vga_line_prefetch
// Purpose  : Ping-pong line prefetcher feeding vga_ctl with 2^SCALE_SH upscaling.
// Revision : 1.0 - initial release
// ============================================================================
module vga_line_prefetch #(
    parameter int                SRC_H    = 480,
    parameter int                SRC_V    = 270,
    parameter int                SCALE_SH = 2,
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] FB_BASE  = '0
) (
    input  wire logic                 pix_clk,
    input  wire logic                 reset,
    input  wire logic                 de,
    input  wire logic [11:0]          hcount,
    input  wire logic [11:0]          vcount,
    output logic [23:0]               rgb,
    output logic                      busy,
    output logic                      underrun,
    vga_line_prefetch_if.master       mem
);

    localparam int c_CNT_W = $clog2(SRC_H + 1);
    localparam int c_IDX_W = $clog2(SRC_H);
    localparam int c_SUM_W = ADDR_W + 12 + c_CNT_W;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(SRC_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_READY = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [11:0]          r_src_line;
    logic [c_CNT_W-1:0]   r_req_cnt;
    logic [c_CNT_W-1:0]   r_ret_cnt;
    logic                 r_disp_bank;
    logic [11:0]          r_line_y;
    logic                 r_de_d;
    logic                 r_underrun;
    logic [23:0]          r_buf [2][SRC_H];

    logic                 w_eol;
    logic                 w_trigger;
    logic                 w_swap;
    logic                 w_ready;
    logic                 w_busy;
    logic                 w_req;
    logic                 w_gnt_fire;
    logic                 w_gnt_last;
    logic                 w_wr;
    logic                 w_wr_last;
    logic                 w_load;
    logic                 w_fill_bank;
    logic [11:0]          w_next_src;
    logic [11:0]          w_col;
    logic [c_SUM_W-1:0]   w_addr_sum;

    assign w_eol       = r_de_d & ~de;
    assign w_trigger   = w_eol & (r_line_y[SCALE_SH-1:0] == '0);
    assign w_swap      = w_eol & (r_line_y[SCALE_SH-1:0] == '1);
    assign w_ready     = (r_state == S_READY);
    assign w_busy      = (r_state == S_ISSUE) | (r_state == S_DRAIN);
    // The fill bank is always the hidden one: a swap only happens once a fill is complete.
    assign w_fill_bank = ~r_disp_bank;

    // Gated by reset so the request only appears once the port is out of reset.
    assign w_req      = (r_state == S_ISSUE) & ~reset;
    assign w_gnt_fire = w_req & mem.mem_gnt;
    assign w_gnt_last = w_gnt_fire & (r_req_cnt == c_LAST);
    assign w_wr       = w_busy & mem.mem_rvalid;
    assign w_wr_last  = w_wr & (r_ret_cnt == c_LAST);

    always_comb begin
        w_next_src = (r_line_y >> SCALE_SH) + 12'd1;
        if (w_next_src == 12'(SRC_V)) begin
            w_next_src = 12'd0;
        end
    end

    assign w_addr_sum = c_SUM_W'(FB_BASE)
                      + c_SUM_W'(r_src_line) * c_SUM_W'(SRC_H)
                      + c_SUM_W'(r_req_cnt);

    assign mem.mem_req  = w_req;
    assign mem.mem_addr = ADDR_W'(w_addr_sum);
    assign busy         = w_busy;
    assign underrun     = r_underrun;

    assign w_col = hcount >> SCALE_SH;
    assign rgb   = (de && (w_col < 12'(SRC_H))) ? r_buf[r_disp_bank][c_IDX_W'(w_col)] : 24'h0;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = S_ISSUE;
                    w_load      = 1'b1;
                end
            end
            S_ISSUE: begin
                // With a zero-latency port the final return can coincide with the final grant.
                if (w_gnt_last) begin
                    w_state_nxt = w_wr_last ? S_READY : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_wr_last) begin
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (w_swap) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            r_state <= S_ISSUE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            r_src_line  <= 12'd0;
            r_req_cnt   <= '0;
            r_ret_cnt   <= '0;
            r_disp_bank <= 1'b0;
            r_line_y    <= 12'd0;
            r_de_d      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_de_d     <= de;
            r_underrun <= w_swap & ~w_ready;
            if (de) begin
                r_line_y <= vcount;
            end
            if (w_swap && w_ready) begin
                r_disp_bank <= ~r_disp_bank;
            end
            if (w_load) begin
                r_src_line <= w_next_src;
                r_req_cnt  <= '0;
                r_ret_cnt  <= '0;
            end else begin
                if (w_gnt_fire) begin
                    r_req_cnt <= r_req_cnt + c_CNT_W'(1);
                end
                if (w_wr) begin
                    r_ret_cnt <= r_ret_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge pix_clk) begin
        if (w_wr) begin
            r_buf[w_fill_bank][c_IDX_W'(r_ret_cnt)] <= mem.mem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_line_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_line_prefetch
// Purpose  : Directed self-checking bench for vga_line_prefetch (8x4 source, 2x scale).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_line_prefetch;

    localparam int c_SRC_H = 8;
    localparam int c_SRC_V = 4;
    localparam int c_SH    = 1;
    localparam int c_AW    = 20;

    typedef struct {
        logic [19:0] addr;
        int          due;
    } pend_t;

    logic        pix_clk = 1'b0;
    logic        reset;
    logic        de;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic [23:0] rgb, rgb2;
    logic        busy, busy2;
    logic        underrun, underrun2;

    int          checks = 0;
    int          failures = 0;
    int          und_cnt = 0;
    int          lat_cfg = 1;
    int          stall_cfg = 0;
    int          gnt_count = 0;
    int          cyc = 0;
    logic [19:0] req_log[$];
    logic [19:0] log2[$];
    pend_t       pend_q[$];

    vga_line_prefetch_if #(.ADDR_W(c_AW)) mif ();
    vga_line_prefetch_if #(.ADDR_W(c_AW)) mif2 ();

    vga_line_prefetch #(
        .SRC_H(c_SRC_H), .SRC_V(c_SRC_V), .SCALE_SH(c_SH), .ADDR_W(c_AW), .FB_BASE(20'h00000)
    ) dut (
        .pix_clk(pix_clk), .reset(reset), .de(de), .hcount(hcount), .vcount(vcount),
        .rgb(rgb), .busy(busy), .underrun(underrun), .mem(mif)
    );

    vga_line_prefetch #(
        .SRC_H(c_SRC_H), .SRC_V(c_SRC_V), .SCALE_SH(c_SH), .ADDR_W(c_AW), .FB_BASE(20'hFFFFC)
    ) dut_wrap (
        .pix_clk(pix_clk), .reset(reset), .de(de), .hcount(hcount), .vcount(vcount),
        .rgb(rgb2), .busy(busy2), .underrun(underrun2), .mem(mif2)
    );

    always #5 pix_clk = ~pix_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: acts 1 time unit after each falling edge, ahead of the next rising edge.
    initial begin : mem_model
        logic        prev_stall;
        logic [19:0] stall_addr;
        int          stall_left;
        pend_t       p;
        prev_stall = 1'b0;
        stall_addr = '0;
        stall_left = 0;
        mif.mem_gnt = 1'b0;  mif.mem_rvalid = 1'b0;  mif.mem_rdata = '0;
        mif2.mem_gnt = 1'b1; mif2.mem_rvalid = 1'b0; mif2.mem_rdata = '0;
        forever begin
            @(negedge pix_clk);
            #1;
            cyc++;
            if (reset) begin
                pend_q.delete();
                mif.mem_gnt    = 1'b0;
                mif.mem_rvalid = 1'b0;
                prev_stall     = 1'b0;
                stall_left     = stall_cfg;
            end else begin
                mif.mem_rvalid = 1'b0;
                mif.mem_rdata  = '0;
                if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    mif.mem_rvalid = 1'b1;
                    mif.mem_rdata  = {4'h0, pend_q[0].addr};
                    void'(pend_q.pop_front());
                end
                if (prev_stall) begin
                    check("stall_req_held", {31'b0, mif.mem_req}, 32'd1);
                    check("stall_addr_held", {12'b0, mif.mem_addr}, {12'b0, stall_addr});
                end
                prev_stall  = 1'b0;
                mif.mem_gnt = 1'b0;
                if (mif.mem_req) begin
                    if (stall_left > 0) begin
                        stall_left--;
                        prev_stall = 1'b1;
                        stall_addr = mif.mem_addr;
                    end else begin
                        mif.mem_gnt = 1'b1;
                        p.addr = mif.mem_addr;
                        p.due  = cyc + lat_cfg;
                        pend_q.push_back(p);
                        req_log.push_back(mif.mem_addr);
                        gnt_count++;
                        stall_left = stall_cfg;
                    end
                end
                if (mif2.mem_req) begin
                    log2.push_back(mif2.mem_addr);
                end
            end
        end
    end

    // One output line: 16 active pixels then 8 blanking cycles.
    task automatic run_line(input int y, input int exp_src, input bit chk);
        for (int x = 0; x < 24; x++) begin
            @(negedge pix_clk);
            if (x < 16) begin
                de = 1'b1; hcount = 12'(x); vcount = 12'(y);
            end else begin
                de = 1'b0; hcount = 12'd0; vcount = 12'd0;
            end
            #2;
            if (underrun === 1'b1) und_cnt++;
            if (chk && x < 16) check($sformatf("rgb_y%0d_x%0d", y, x), {8'b0, rgb}, 32'(8 * exp_src + x / 2));
            if (x == 16) check("rgb_blank", {8'b0, rgb}, 32'd0);
        end
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(negedge pix_clk);
            #2;
            n++;
        end
        check("fill_done", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int base;
        int n;
        reset = 1'b1; de = 1'b0; hcount = '0; vcount = '0;

        // Reset values and initial fill
        repeat (3) @(negedge pix_clk);
        #2;
        check("rst_mem_req", {31'b0, mif.mem_req}, 32'd0);
        check("rst_mem_addr", {12'b0, mif.mem_addr}, 32'd0);
        check("rst_underrun", {31'b0, underrun}, 32'd0);
        check("rst_rgb", {8'b0, rgb}, 32'd0);
        @(negedge pix_clk);
        reset = 1'b0;
        #2;
        check("rel_mem_req", {31'b0, mif.mem_req}, 32'd1);
        check("rel_mem_addr", {12'b0, mif.mem_addr}, 32'd0);
        check("rel_busy", {31'b0, busy}, 32'd1);
        wait_idle(100);
        check("init_req_count", req_log.size(), 32'd8);
        for (int i = 0; i < 8 && i < req_log.size(); i++) check("init_addr", {12'b0, req_log[i]}, 32'(i));
        check("wrap_req_count", log2.size(), 32'd8);
        for (int i = 0; i < 8 && i < log2.size(); i++)
            check("wrap_addr", {12'b0, log2[i]}, 32'((20'hFFFFC + i) % 32'h100000));

        // Frame 1: startup sequence, bank 0 undefined on lines 0-1
        req_log.delete();
        run_line(0, 0, 1'b0);
        run_line(1, 0, 1'b0);
        run_line(2, 0, 1'b1);
        run_line(3, 0, 1'b1);
        run_line(4, 2, 1'b1);
        run_line(5, 2, 1'b1);
        run_line(6, 3, 1'b1);
        run_line(7, 3, 1'b1);
        check("f1_req_count", req_log.size(), 32'd24);
        if (req_log.size() >= 24) begin
            check("f1_src2_base", {12'b0, req_log[0]}, 32'd16);
            check("f1_src3_base", {12'b0, req_log[8]}, 32'd24);
            check("f1_wrap_first", {12'b0, req_log[16]}, 32'd0);
            check("f1_wrap_last", {12'b0, req_log[23]}, 32'd7);
        end

        // Frame 2: steady state, lines 2k/2k+1 show source k
        for (int y = 0; y < 8; y++) run_line(y, y / 2, 1'b1);
        check("f2_no_underrun", und_cnt, 32'd0);

        // Frame 3: slow memory from line 2 on forces underruns
        run_line(0, 0, 1'b1);
        run_line(1, 0, 1'b1);
        lat_cfg = 30;
        run_line(2, 1, 1'b1);
        run_line(3, 1, 1'b1);
        check("slow_underrun_once", und_cnt, 32'd1);
        run_line(4, 1, 1'b1);
        run_line(5, 1, 1'b1);
        check("slow_no_extra_underrun", und_cnt, 32'd1);
        run_line(6, 2, 1'b1);
        run_line(7, 2, 1'b1);
        check("slow_second_underrun", und_cnt, 32'd2);

        // Stalled grants, then reset mid-fill
        @(negedge pix_clk);
        reset = 1'b1;
        lat_cfg = 1;
        stall_cfg = 3;
        repeat (3) @(negedge pix_clk);
        reset = 1'b0;
        #2;
        base = gnt_count;
        n = 0;
        while ((gnt_count - base) < 4 && n < 100) begin
            @(negedge pix_clk);
            #2;
            n++;
        end
        check("midfill_grants", gnt_count - base, 32'd4);
        @(negedge pix_clk);
        reset = 1'b1;
        #2;
        check("midrst_mem_req", {31'b0, mif.mem_req}, 32'd0);
        check("midrst_underrun", {31'b0, underrun}, 32'd0);
        repeat (2) @(negedge pix_clk);
        req_log.delete();
        und_cnt = 0;
        @(negedge pix_clk);
        reset = 1'b0;
        #2;
        check("restart_addr", {12'b0, mif.mem_addr}, 32'd0);
        check("restart_req", {31'b0, mif.mem_req}, 32'd1);
        wait_idle(200);
        check("stall_req_count", req_log.size(), 32'd8);
        for (int i = 0; i < 8 && i < req_log.size(); i++) check("stall_addr_seq", {12'b0, req_log[i]}, 32'(i));
        stall_cfg = 0;
        run_line(0, 0, 1'b0);
        run_line(1, 0, 1'b0);
        run_line(2, 0, 1'b1);
        run_line(3, 0, 1'b1);
        check("post_reset_underrun", und_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
